div_unit: RTL and testbench

Multi-cycle 32-bit integer divider serving the execute stage for DIV, DIVU, REM and REMU. The execute stage holds `start_i` and stalls the pipeline until `ready_o` rises, then consumes `result_o`. The quotient goes in the low word and the remainder in the high word. The unit is a radix-2 restoring divider, one quotient bit per cycle, with RISC-V divide-by-zero and overflow semantics.

---
 rtl/div_unit_pkg.sv | 25 ++
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
//   Shared definitions for the execute-stage integer divider: bus widths,
//   handshake levels and the divider state encoding.
// -----------------------------------------------------------------------------
package div_unit_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;

    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    localparam logic DIV_START           = 1'b1;
    localparam logic DIV_STOP            = 1'b0;
    localparam logic DIV_RESULT_READY    = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU/REM/REMU.
//   One quotient bit per cycle; RISC-V divide-by-zero and overflow results.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   signed_div_i 1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      request, held by the producer until ready_o
//   annul_i      flush: abort the operation in flight (beats start_i)
//   result_o     {remainder, quotient}, registered
//   ready_o      high while result_o is valid, registered
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [REG_BUS-1:0]        opdata1_i,
    input  logic [REG_BUS-1:0]        opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DOUBLE_REG_BUS-1:0] result_o,
    output logic                      ready_o
);

    // Magnitude of a two's-complement word. 0x8000_0000 maps to itself,
    // which is exactly the unsigned magnitude we need for the overflow case.
    function automatic logic [REG_BUS-1:0] abs_word(input logic signed [REG_BUS-1:0] v);
        logic signed [REG_BUS-1:0] n;
        n = -v;
        return v[REG_BUS-1] ? n : v;
    endfunction

    function automatic logic [REG_BUS-1:0] neg_if(input logic [REG_BUS-1:0] v,
                                                  input logic              en);
        logic signed [REG_BUS-1:0] s;
        s = $signed(v);
        return en ? -s : s;
    endfunction

    div_state_e         state;
    logic [4:0]         cnt;
    // Shift register: starts as the dividend magnitude, and the quotient bits
    // are shifted in from the bottom as dividend bits leave from the top.
    logic [REG_BUS-1:0] dividend;
    logic [REG_BUS-1:0] rem;
    logic [REG_BUS-1:0] divisor;
    logic               qneg;
    logic               rneg;

    logic [REG_BUS:0]          rem_sh;
    logic signed [REG_BUS:0]   trial;
    logic                      qbit;
    logic [REG_BUS-1:0]        rem_nxt;
    logic [REG_BUS-1:0]        quo_nxt;
    logic                      abort;

    // One restoring step. rem < divisor always holds, so the shifted
    // remainder is below 2*divisor and the difference fits 33 signed bits.
    always_comb begin
        rem_sh  = {rem, dividend[REG_BUS-1]};
        trial   = $signed(rem_sh - {1'b0, divisor});
        qbit    = ~trial[REG_BUS];
        rem_nxt = qbit ? trial[REG_BUS-1:0] : rem_sh[REG_BUS-1:0];
        quo_nxt = {dividend[REG_BUS-2:0], qbit};
        abort   = annul_i || (start_i == DIV_STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o  <= DIV_RESULT_NOT_READY;
                    result_o <= '0;
                    if (start_i == DIV_START && !annul_i) begin
                        qneg <= signed_div_i & (opdata1_i[REG_BUS-1] ^ opdata2_i[REG_BUS-1]);
                        rneg <= signed_div_i & opdata1_i[REG_BUS-1];
                        if (opdata2_i == ZERO_WORD) begin
                            // Raw dividend: the remainder of x/0 is x in both modes.
                            dividend <= opdata1_i;
                            state    <= DIV_BY_ZERO;
                        end else begin
                            dividend <= signed_div_i ? abs_word($signed(opdata1_i)) : opdata1_i;
                            divisor  <= signed_div_i ? abs_word($signed(opdata2_i)) : opdata2_i;
                            rem      <= ZERO_WORD;
                            cnt      <= '0;
                            state    <= DIV_ON;
                        end
                    end
                end

                DIV_BY_ZERO: begin
                    if (abort) begin
                        state    <= DIV_FREE;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end else begin
                        result_o <= {dividend, ~ZERO_WORD};
                        ready_o  <= DIV_RESULT_READY;
                        state    <= DIV_END;
                    end
                end

                DIV_ON: begin
                    if (abort) begin
                        state    <= DIV_FREE;
                        cnt      <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end else begin
                        dividend <= quo_nxt;
                        rem      <= rem_nxt;
                        cnt      <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            result_o <= {neg_if(rem_nxt, rneg), neg_if(quo_nxt, qneg)};
                            ready_o  <= DIV_RESULT_READY;
                            state    <= DIV_END;
                        end
                    end
                end

                DIV_END: begin
                    // Result is held until the producer releases start_i.
                    if (abort) begin
                        state    <= DIV_FREE;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end
                end

                default: begin
                    state    <= DIV_FREE;
                    ready_o  <= DIV_RESULT_NOT_READY;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Scoreboard bench for div_unit: expected results are queued when an
//   operation is driven and compared when ready_o rises.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V division computed with 64-bit host arithmetic.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            res = {r[31:0], q[31:0]};
        end else begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            uq = ua / ub;
            ur = ua % ub;
            res = {ur[31:0], uq[31:0]};
        end
        return res;
    endfunction

    // Called during cycle 0 of an accepted operation (after its negedge or
    // before it; outputs are registered). Waits for ready_o, scoring latency
    // and result, optionally holds start_i, then releases the handshake.
    task automatic wait_result(input int exp_lat, input string tag, input int hold);
        int          cyc;
        logic        got;
        logic [63:0] exp;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            op1 = $urandom;
            op2 = $urandom;
            signed_div = 1'($urandom);
            @(negedge clk);
            got = ready;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            check(tag, result, exp);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
                check({tag, "_hold_res"}, result, exp);
            end
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rel_rdy"}, 64'(ready), 64'd0);
        check({tag, "_rel_res"}, result, 64'd0);
    endtask

    task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input int hold);
        @(posedge clk); #1;
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        exp_q.push_back(model(sgn, a, b));
        wait_result((b == 32'd0) ? 2 : 33, tag, hold);
    endtask

    // Interrupt an operation in cycle 10 (annul or start drop), then start a
    // fresh one in cycle 11 and expect it to complete normally.
    task automatic abort_test(input logic use_annul, input string tag);
        logic rose;
        rose = 1'b0;
        @(posedge clk); #1;
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd3;
        start      = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 10) begin
                if (use_annul) annul = 1'b1;
                else           start = 1'b0;
            end
            @(negedge clk);
            rose = rose | ready;
        end
        check({tag, "_no_ready"}, 64'(rose), 64'd0);
        @(posedge clk); #1;
        annul      = 1'b0;
        start      = 1'b1;
        signed_div = 1'b1;
        op1        = 32'hFFFF_F000;
        op2        = 32'd67;
        exp_q.push_back(model(1'b1, 32'hFFFF_F000, 32'd67));
        @(negedge clk);
        check({tag, "_free_rdy"}, 64'(ready), 64'd0);
        check({tag, "_free_res"}, result, 64'd0);
        wait_result(33, {tag, "_restart"}, 0);
    endtask

    task automatic reset_test();
        logic rose;
        rose = 1'b0;
        @(posedge clk); #1;
        signed_div = 1'b0;
        op1        = 32'd5000;
        op2        = 32'd9;
        start      = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 20) rst = 1'b1;
            @(negedge clk);
            rose = rose | ready;
        end
        check("rst_mid_no_ready", 64'(rose), 64'd0);
        @(posedge clk); #1;
        rst        = 1'b0;
        signed_div = 1'b0;
        op1        = 32'd77777;
        op2        = 32'd13;
        exp_q.push_back(model(1'b0, 32'd77777, 32'd13));
        @(negedge clk);
        check("rst_mid_rdy", 64'(ready), 64'd0);
        check("rst_mid_res", result, 64'd0);
        wait_result(33, "rst_restart", 0);
    endtask

    initial begin
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        op1        = 32'd0;
        op2        = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdy", 64'(ready), 64'd0);
        check("reset_res", result, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(1'b0, 32'd100,        32'd7,          "u100_7",   0);
        do_op(1'b1, 32'hFFFF_FFF9,  32'd2,          "s-7_2",    0);
        do_op(1'b0, 32'hFFFF_FFF9,  32'd2,          "uFFF9_2",  0);
        do_op(1'b1, 32'h0000_1234,  32'd0,          "s_div0",   0);
        do_op(1'b0, 32'd0,          32'd0,          "u0_0",     0);
        do_op(1'b1, 32'hFFFF_FFFB,  32'd0,          "s_neg_div0", 0);
        do_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  "s_ovf",    0);
        do_op(1'b0, 32'hFFFF_FFFF,  32'd1,          "u_max_1",  0);
        do_op(1'b0, 32'd5,          32'hFFFF_FFFF,  "u_small_big", 0);
        do_op(1'b1, 32'd7,          32'hFFFF_FFFE,  "s7_-2",    3);

        abort_test(1'b1, "annul");
        abort_test(1'b0, "stopdrop");
        reset_test();

        for (int i = 0; i < 600; i++) begin
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = $urandom_range(1, 15);
                default: ;
            endcase
            do_op(s, a, b, "rand", 0);
        end

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
